// File: rtl/iiitb_prog_seq_det.sv
// Programmable serial sequence detector: runtime-loaded pattern/length,
// overlapping or non-overlapping matching, saturating match counter.
module iiitb_prog_seq_det #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state_out
);

  typedef enum logic [1:0] {
    UNCFG = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b11
  } state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] hist_q, pat_q;
  logic [LEN_W-1:0]   len_q, fill_q;
  logic               ovl_q;

  logic [LEN_W-1:0]   cfg_len_c, fill_n;
  logic [MAX_LEN-1:0] hist_n, mask;
  logic               match;

  assign cfg_len_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  assign hist_n    = {hist_q[MAX_LEN-2:0], sequence_in};
  assign fill_n    = (fill_q == len_q) ? fill_q : fill_q + 1'b1;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
  end

  assign match = (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= UNCFG;
      hist_q       <= '0;
      pat_q        <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      ovl_q        <= 1'b0;
      detector_out <= 1'b0;
      match_count  <= '0;
    end else if (cfg_load) begin
      // Reconfiguration wins over any bit presented in the same cycle.
      pat_q        <= cfg_pattern;
      len_q        <= cfg_len_c;
      ovl_q        <= cfg_overlap;
      hist_q       <= '0;
      fill_q       <= '0;
      match_count  <= '0;
      detector_out <= 1'b0;
      state_q      <= (cfg_len_c < LEN_W'(2)) ? UNCFG : FILL;
    end else begin
      detector_out <= 1'b0;
      case (state_q)
        UNCFG: ;
        FILL, ARMED: begin
          if (in_valid) begin
            hist_q       <= hist_n;
            detector_out <= match;
            if (match) begin
              if (match_count != '1) match_count <= match_count + 1'b1;
              // Non-overlapping: restart the fill so matched bits can't be reused.
              if (ovl_q) begin
                fill_q  <= fill_n;
                state_q <= ARMED;
              end else begin
                fill_q  <= '0;
                state_q <= FILL;
              end
            end else begin
              fill_q  <= fill_n;
              state_q <= (fill_n == len_q) ? ARMED : FILL;
            end
          end
        end
        default: state_q <= UNCFG;
      endcase
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_iiitb_prog_seq_det.sv
// Randomized and directed bench for iiitb_prog_seq_det against a queue-based
// model of the detector's matching rules.
module tb_iiitb_prog_seq_det;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sequence_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       detector_out, detector_out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [1:0] state_out, state_out2;

  iiitb_prog_seq_det dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .detector_out(detector_out),
    .match_count(match_count), .state_out(state_out)
  );

  iiitb_prog_seq_det #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .detector_out(detector_out2),
    .match_count(match_count2), .state_out(state_out2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the valid bits seen since configuration (or since the
  // last non-overlapping match), trimmed to the pattern length.
  bit         mcfg;
  logic [7:0] mpat;
  int         mlen;
  bit         movl;
  bit         mq[$];
  int         mcnt, mcnt2;
  logic       exp_det;

  task automatic model_reset();
    mcfg = 0; mq.delete(); mcnt = 0; mcnt2 = 0; exp_det = 0;
  endtask

  task automatic model_load(input logic [7:0] p, input int l, input bit o);
    mlen = (l > 8) ? 8 : l;
    mpat = p; movl = o; mq.delete(); mcnt = 0; mcnt2 = 0; exp_det = 0;
    mcfg = (mlen >= 2);
  endtask

  task automatic model_bit(input bit b);
    bit ok;
    exp_det = 0;
    if (!mcfg) return;
    mq.push_back(b);
    if (mq.size() > mlen) void'(mq.pop_front());
    if (mq.size() == mlen) begin
      ok = 1;
      for (int i = 0; i < mlen; i++) if (mq[i] != mpat[mlen-1-i]) ok = 0;
      if (ok) begin
        exp_det = 1;
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
        if (!movl) mq.delete();
      end
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (!mcfg) return 2'b00;
    return (mq.size() == mlen) ? 2'b11 : 2'b01;
  endfunction

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit b, input bit v);
    sequence_in = b; in_valid = v;
    if (v) model_bit(b); else exp_det = 0;
    @(posedge clock); #1;
  endtask

  task automatic do_load(input logic [7:0] p, input int l, input bit o);
    cfg_load = 1; cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = o;
    in_valid = 1; sequence_in = 1'($urandom);
    model_load(p, l, o);
    @(posedge clock); #1;
    cfg_load = 0;
    cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1; model_reset(); #1;
    n_checks++;
    if (state_out !== 2'b00 || detector_out !== 1'b0 || match_count !== 8'd0)
      $display("FAIL reset_asserted: state=%b det=%b cnt=%0d, want 00/0/0", state_out, detector_out, match_count);
    else n_pass++;
    @(posedge clock); #1; reset = 0;
    @(posedge clock); #1;
    n_checks++;
    if (state_out !== 2'b00 || detector_out !== 1'b0 || match_count !== 8'd0)
      $display("FAIL reset_released: state=%b det=%b cnt=%0d, want 00/0/0", state_out, detector_out, match_count);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom), 1);
      n_checks++;
      if (detector_out !== 1'b0 || state_out !== 2'b00)
        $display("FAIL unconfigured_bit%0d: det=%b state=%b, want 0/00", i, detector_out, state_out);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    bit s[5] = '{1, 0, 1, 1, 1};
    do_load(8'b10111, 5, 1);
    n_checks++;
    if (state_out !== 2'b01 || detector_out !== 1'b0)
      $display("FAIL basic_after_load: state=%b det=%b, want 01/0", state_out, detector_out);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(s[i], 1);
      n_checks++;
      if (detector_out !== (i == 4) || detector_out !== exp_det)
        $display("FAIL basic_bit%0d: det=%b, want %b", i, detector_out, exp_det);
      else n_pass++;
    end
    n_checks++;
    if (match_count !== 8'd1 || state_out !== 2'b11)
      $display("FAIL basic_count: cnt=%0d state=%b, want 1/11", match_count, state_out);
    else n_pass++;
    drive(0, 0);
    n_checks++;
    if (detector_out !== 1'b0)
      $display("FAIL basic_one_cycle: det=%b, want 0", detector_out);
    else n_pass++;
  endtask

  task automatic test_overlap();
    bit s[6] = '{1, 0, 1, 0, 1, 0};
    int pulses;
    for (int o = 0; o < 2; o++) begin
      do_load(8'b1010, 4, 1'(o));
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        drive(s[i], 1);
        pulses += int'(detector_out);
        n_checks++;
        if (detector_out !== exp_det)
          $display("FAIL overlap%0d_bit%0d: det=%b, want %b", o, i, detector_out, exp_det);
        else n_pass++;
      end
      n_checks++;
      if (pulses != (o ? 2 : 1) || match_count !== 8'(o ? 2 : 1))
        $display("FAIL overlap%0d_pulses: pulses=%0d cnt=%0d, want %0d", o, pulses, match_count, o ? 2 : 1);
      else n_pass++;
    end
  endtask

  task automatic test_gaps();
    bit s[5] = '{1, 0, 1, 1, 1};
    int pulses = 0;
    do_load(8'b10111, 5, 1);
    for (int i = 0; i < 5; i++) begin
      drive(s[i], 1);
      pulses += int'(detector_out);
      n_checks++;
      if (detector_out !== (i == 4))
        $display("FAIL gaps_valid%0d: det=%b, want %b", i, detector_out, i == 4);
      else n_pass++;
      for (int g = 0; g <= i % 3; g++) begin
        drive(1'($urandom), 0);
        pulses += int'(detector_out);
      end
    end
    n_checks++;
    if (pulses != 1 || match_count !== 8'd1)
      $display("FAIL gaps_pulses: pulses=%0d cnt=%0d, want 1", pulses, match_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    do_load(8'b11, 2, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1);
      pulses += int'(detector_out2);
      n_checks++;
      if (detector_out2 !== exp_det || match_count2 !== 2'(mcnt2))
        $display("FAIL sat_bit%0d: det=%b cnt=%0d, want %b/%0d", i, detector_out2, match_count2, exp_det, mcnt2);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 5 || match_count2 !== 2'd3 || match_count !== 8'd5)
      $display("FAIL sat_total: pulses=%0d cnt2=%0d cnt8=%0d, want 5/3/5", pulses, match_count2, match_count);
    else n_pass++;
  endtask

  task automatic test_abort();
    int pulses = 0;
    do_load(8'b10111, 5, 1);
    drive(1, 1); drive(0, 1); drive(1, 1);
    reset = 1; model_reset(); #1;
    n_checks++;
    if (state_out !== 2'b00 || detector_out !== 1'b0)
      $display("FAIL abort_reset: state=%b det=%b, want 00/0", state_out, detector_out);
    else n_pass++;
    @(posedge clock); #1; reset = 0;
    drive(1, 1); pulses += int'(detector_out);
    drive(1, 1); pulses += int'(detector_out);
    n_checks++;
    if (pulses != 0 || state_out !== 2'b00)
      $display("FAIL abort_reset_tail: pulses=%0d state=%b, want 0/00", pulses, state_out);
    else n_pass++;
    do_load(8'b10111, 5, 1);
    drive(1, 1); drive(0, 1); drive(1, 1);
    do_load(8'b10111, 5, 1);
    pulses = 0;
    drive(1, 1); pulses += int'(detector_out);
    drive(1, 1); pulses += int'(detector_out);
    n_checks++;
    if (pulses != 0 || state_out !== 2'b01)
      $display("FAIL abort_cfg_tail: pulses=%0d state=%b, want 0/01", pulses, state_out);
    else n_pass++;
  endtask

  task automatic test_len_edges();
    bit s[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    do_load(8'hFF, 1, 1);
    drive(1, 1); drive(1, 1);
    n_checks++;
    if (state_out !== 2'b00 || detector_out !== 1'b0)
      $display("FAIL len1_uncfg: state=%b det=%b, want 00/0", state_out, detector_out);
    else n_pass++;
    // Length 12 clamps to 8: pattern A5 must match after exactly 8 bits.
    do_load(8'hA5, 12, 1);
    for (int i = 0; i < 8; i++) begin
      drive(s[i], 1);
      n_checks++;
      if (detector_out !== (i == 7))
        $display("FAIL clamp_bit%0d: det=%b, want %b", i, detector_out, i == 7);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    int l;
    for (int c = 0; c < 25; c++) begin
      p = 8'($urandom);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 5);
      do_load(p, l, 1'($urandom));
      for (int i = 0; i < 40; i++) begin
        drive(($urandom_range(0, 1) == 1) ? p[$urandom_range(0, 7)] : 1'($urandom),
              $urandom_range(0, 4) != 0);
        n_checks++;
        if (detector_out !== exp_det || match_count !== 8'(mcnt) || state_out !== exp_state()
            || match_count2 !== 2'(mcnt2))
          $display("FAIL random_c%0d_b%0d: det=%b cnt=%0d st=%b cnt2=%0d, want %b/%0d/%b/%0d",
                   c, i, detector_out, match_count, state_out, match_count2,
                   exp_det, mcnt, exp_state(), mcnt2);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_saturation();
    test_abort();
    test_len_edges();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iiitb_prog_seq_det.md
IIITB_PROG_SEQ_DET -- requirements
Module: iiitb_prog_seq_det

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter LEN_W, default 4, width of cfg_len; SHALL satisfy 2^LEN_W > MAX_LEN.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sequence_in  input  1  serial data bit.
REQ-007 in_valid  input  1  sequence_in is sampled only when high.
REQ-008 cfg_load  input  1  single-cycle strobe that loads the configuration.
REQ-009 cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is oldest, bit 0 newest.
REQ-010 cfg_len  input  LEN_W  pattern length in bits.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 detector_out  output  1  registered one-cycle match pulse.
REQ-013 match_count  output  CNT_W  saturating count of matches.
REQ-014 state_out  output  2  current FSM state.

Function
REQ-015 The FSM SHALL have states UNCFG=2'b00, FILL=2'b01 and ARMED=2'b11; any other code SHALL go to UNCFG on the next clock.
REQ-016 On cfg_load, the block SHALL latch pattern, length and overlap mode, clear the history and fill count, and clear match_count.
REQ-017 After a cfg_load, the next state SHALL be UNCFG if cfg_len is 0 or 1, and FILL otherwise.
REQ-018 A cfg_len greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-019 In UNCFG, all input bits SHALL be ignored and detector_out SHALL stay 0.
REQ-020 On each clock with in_valid=1 in FILL or ARMED:
  - the history SHALL shift left with sequence_in entering bit 0;
  - the fill count SHALL increment, saturating at len.
REQ-021 A clock with in_valid=0 SHALL leave the history, fill count and state unchanged.
REQ-022 The FSM SHALL go from FILL to ARMED when the fill count reaches len.
REQ-023 A match SHALL occur on a valid bit when, after the shift, the fill count is at least len and history[len-1:0] equals pattern[len-1:0].
REQ-024 Match latency: detector_out SHALL be high for exactly the one cycle after the clock edge that sampled the completing bit.
REQ-025 Consecutive matching bits SHALL give consecutive detector_out pulses.
REQ-026 On a match with overlap=0:
  - the fill count SHALL be cleared;
  - the state SHALL return to FILL;
  - no bit of the matched pattern SHALL contribute to a later match.
REQ-027 On a match with overlap=1, the history SHALL be kept and the state SHALL stay ARMED.
REQ-028 match_count SHALL increment by 1 on each match and saturate at 2^CNT_W-1.
REQ-029 cfg_load SHALL take priority over in_valid in the same cycle:
  - the incoming bit SHALL be discarded;
  - no match SHALL be generated;
  - detector_out SHALL be 0 in the following cycle.
REQ-030 cfg_pattern, cfg_len and cfg_overlap SHALL be ignored while cfg_load is low.

Reset
REQ-031 While reset is high, all of the following SHALL hold asynchronously: state = UNCFG; history, fill count and stored config = 0; detector_out = 0; match_count = 0.
REQ-032 After reset is released, the block SHALL stay in UNCFG until the first cfg_load.
REQ-033 A reset asserted mid-stream SHALL abort any partial match; no pulse SHALL be generated for that partial match.

Verification
REQ-034 Reset check: assert reset, then release -> state_out=00, detector_out=0, match_count=0; bits fed with in_valid=1 and no cfg_load -> no pulse.
REQ-035 Basic match: load pattern 5'b10111, len 5, overlap 1; feed 1,0,1,1,1 -> detector_out pulses one cycle after the 5th bit and match_count=1.
REQ-036 Overlap mode: load pattern 4'b1010, len 4; feed 1,0,1,0,1,0.
  - overlap=1 -> two pulses (after bits 4 and 6).
  - overlap=0 -> one pulse (after bit 4).
REQ-037 Valid gaps: feed the bits of the REQ-035 stream with in_valid=0 cycles inserted between them -> exactly one pulse, one cycle after the last valid bit.
REQ-038 Saturation with CNT_W=2: pattern 2'b11, len 2, overlap 1; feed six 1s -> five pulses and match_count=3.
REQ-039 Mid-stream aborts:
  - reset after bits 1,0,1 of the REQ-035 stream -> no pulse, state UNCFG;
  - cfg_load after those bits, then feed 1,1 -> no pulse.
